// File: rtl/rename_pkg.sv
// rename_pkg
//   Constants shared by the rename stage and the rename commit queue:
//   default physical-name width, default commit queue depth and pointer width,
//   and a helper that checks a queue depth is a power of two no smaller than 2.
//   No ports (package only).
package rename_pkg;

    localparam int NAME_WIDTH    = 1;
    localparam int RCQ_DEPTH     = 4;
    localparam int RCQ_PTR_WIDTH = $clog2(RCQ_DEPTH);

    // Head/tail pointers wrap by plain overflow, which only works for a
    // power-of-two depth.
    function automatic bit is_pow2_depth(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/rename_commit_queue_match_vec.sv
// rcq_match_vec
//   Depth-wide writeback comparator. Flags every valid entry whose stored
//   physical name equals the writeback name while the writeback strobe is
//   high. In-flight names are unique, so the result is one-hot or zero.
// Ports
//   wb_name  in   name_width        name written back this cycle
//   wb_e     in   1                 writeback strobe
//   names    in   depth*name_width  entry names, entry i at [i*name_width +: name_width]
//   valid    in   depth             entry valid bits
//   match    out  depth             done-set vector, one bit per entry
module rcq_match_vec #(
    parameter int name_width = 1,
    parameter int depth      = 4
) (
    input  logic [name_width-1:0]       wb_name,
    input  logic                        wb_e,
    input  logic [depth*name_width-1:0] names,
    input  logic [depth-1:0]            valid,
    output logic [depth-1:0]            match
);

    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_cmp
            assign match[gi] = wb_e && valid[gi] &&
                               (names[gi*name_width +: name_width] == wb_name);
        end
    endgenerate

endmodule

// File: rtl/rename_commit_queue.sv
// rename_commit_queue
//   In-order commit tracker for the rename register file. Records every
//   allocated physical name in program order, marks entries done on
//   writeback, and retires the oldest entry once it is done and downstream
//   allows it, by pulsing the free request (NAME_F/FE) into the rename file.
// Ports
//   CLK           in   1           clock, all state on posedge
//   RST           in   1           asynchronous active-low reset
//   ENQ_NAME      in   name_width  name just allocated by rename
//   ENQ_E         in   1           enqueue strobe, taken only when ENQ_READY
//   ENQ_READY     out  1           queue not full
//   WB_NAME       in   name_width  name whose data was written this cycle
//   WB_E          in   1           writeback strobe
//   COMMIT_READY  in   1           downstream permits a retire this cycle
//   NAME_F        out  name_width  head entry name (0 when empty)
//   FE            out  1           free strobe to the rename file
//   EMPTY         out  1           queue holds no entries
// Optional feature (macro RCQ_COMMIT_STATS_EN)
//   COMMIT_COUNT  out  32  number of FE cycles since reset (wraps)
//   STALL_COUNT   out  32  cycles with a valid head that could not retire (wraps)
module rename_commit_queue
    import rename_pkg::*;
#(
    parameter int name_width = NAME_WIDTH,
    parameter int depth      = RCQ_DEPTH,
    parameter int ptr_width  = RCQ_PTR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [name_width-1:0] ENQ_NAME,
    input  logic                  ENQ_E,
    output logic                  ENQ_READY,
    input  logic [name_width-1:0] WB_NAME,
    input  logic                  WB_E,
    input  logic                  COMMIT_READY,
    output logic [name_width-1:0] NAME_F,
    output logic                  FE,
    output logic                  EMPTY
`ifdef RCQ_COMMIT_STATS_EN
    ,
    output logic [31:0]           COMMIT_COUNT,
    output logic [31:0]           STALL_COUNT
`endif
);

    localparam int                 CNT_W      = ptr_width + 1;
    localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(depth);

    generate
        if (!is_pow2_depth(depth) || (ptr_width != $clog2(depth))) begin : g_bad_cfg
            $error("rename_commit_queue: depth must be a power of two >= 2 and ptr_width = log2(depth)");
        end
    endgenerate

    logic [name_width-1:0]       name_reg [depth];
    logic [depth-1:0]            valid_reg;
    logic [depth-1:0]            done_reg;
    logic [ptr_width-1:0]        head_reg;
    logic [ptr_width-1:0]        tail_reg;
    logic [CNT_W-1:0]            count_reg;

    logic [depth*name_width-1:0] names_flat;
    logic [depth-1:0]            wb_match;
    logic [depth-1:0]            enq_sel;
    logic [depth-1:0]            com_sel;
    logic                        head_valid;
    logic                        head_done;
    logic                        enq_fire;
    logic                        commit_fire;
    logic                        enq_wb_same;

    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_entry
            localparam logic [ptr_width-1:0] IDX = ptr_width'(gi);
            assign names_flat[gi*name_width +: name_width] = name_reg[gi];
            assign enq_sel[gi] = enq_fire && (tail_reg == IDX);
            assign com_sel[gi] = commit_fire && (head_reg == IDX);
        end
    endgenerate

    rcq_match_vec #(
        .name_width (name_width),
        .depth      (depth)
    ) u_match (
        .wb_name (WB_NAME),
        .wb_e    (WB_E),
        .names   (names_flat),
        .valid   (valid_reg),
        .match   (wb_match)
    );

    assign head_valid  = valid_reg[head_reg];
    assign head_done   = done_reg[head_reg];
    // Retire decision uses registered done only: a writeback of the head
    // name this cycle can retire it next cycle at the earliest.
    assign commit_fire = head_valid && head_done && COMMIT_READY;
    // Readiness depends on count alone, so a full queue that retires this
    // cycle still refuses the enqueue.
    assign ENQ_READY   = (count_reg != FULL_COUNT);
    assign enq_fire    = ENQ_E && ENQ_READY;
    // A writeback racing the enqueue of the same name must not be lost.
    assign enq_wb_same = WB_E && (WB_NAME == ENQ_NAME);

    assign FE     = commit_fire;
    assign NAME_F = head_valid ? name_reg[head_reg] : '0;
    assign EMPTY  = (count_reg == '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (enq_fire) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (commit_fire) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({enq_fire, commit_fire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Enqueue and commit never select the same slot: a slot that is both
    // tail and head with entries present means the queue is full, and a full
    // queue does not enqueue.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < depth; i++) begin
                name_reg[i] <= '0;
            end
            valid_reg <= '0;
            done_reg  <= '0;
        end else begin
            for (int i = 0; i < depth; i++) begin
                if (enq_sel[i]) begin
                    name_reg[i]  <= ENQ_NAME;
                    valid_reg[i] <= 1'b1;
                    done_reg[i]  <= enq_wb_same;
                end else if (com_sel[i]) begin
                    valid_reg[i] <= 1'b0;
                    done_reg[i]  <= 1'b0;
                end else if (wb_match[i]) begin
                    done_reg[i]  <= 1'b1;
                end
            end
        end
    end

`ifdef RCQ_COMMIT_STATS_EN
    logic [31:0] commit_count_reg;
    logic [31:0] stall_count_reg;
    logic        stall_cycle;

    assign stall_cycle = head_valid && (!head_done || !COMMIT_READY);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            commit_count_reg <= '0;
            stall_count_reg  <= '0;
        end else begin
            if (commit_fire) begin
                commit_count_reg <= commit_count_reg + 32'd1;
            end
            if (stall_cycle) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end

    assign COMMIT_COUNT = commit_count_reg;
    assign STALL_COUNT  = stall_count_reg;
`endif

endmodule

// File: tb/tb_rename_commit_queue.sv
// tb_rename_commit_queue
//   Self-checking bench for rename_commit_queue (name_width=4, depth=4).
//   Directed vector table, hand sequences for reset and backpressure, then
//   randomized traffic against a queue-based reference model.
//   Build with RCQ_COMMIT_STATS_EN defined to also check the counters.
module tb_rename_commit_queue;

    localparam int NW = 4;
    localparam int D  = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [NW-1:0] ENQ_NAME;
    logic          ENQ_E;
    logic          ENQ_READY;
    logic [NW-1:0] WB_NAME;
    logic          WB_E;
    logic          COMMIT_READY;
    logic [NW-1:0] NAME_F;
    logic          FE;
    logic          EMPTY;
`ifdef RCQ_COMMIT_STATS_EN
    logic [31:0]   COMMIT_COUNT;
    logic [31:0]   STALL_COUNT;
`endif

    always #5 CLK = ~CLK;

    rename_commit_queue #(
        .name_width (NW),
        .depth      (D),
        .ptr_width  (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ENQ_NAME     (ENQ_NAME),
        .ENQ_E        (ENQ_E),
        .ENQ_READY    (ENQ_READY),
        .WB_NAME      (WB_NAME),
        .WB_E         (WB_E),
        .COMMIT_READY (COMMIT_READY),
        .NAME_F       (NAME_F),
        .FE           (FE),
        .EMPTY        (EMPTY)
`ifdef RCQ_COMMIT_STATS_EN
        ,
        .COMMIT_COUNT (COMMIT_COUNT),
        .STALL_COUNT  (STALL_COUNT)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ee, input int en, input logic we, input int wn, input logic cr);
        ENQ_E        = ee;
        ENQ_NAME     = NW'(en);
        WB_E         = we;
        WB_NAME      = NW'(wn);
        COMMIT_READY = cr;
    endtask

    // Advance to just after the next active edge, where inputs are driven.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic          enq_e;
        logic [NW-1:0] enq_name;
        logic          wb_e;
        logic [NW-1:0] wb_name;
        logic          cr;
        logic          fe;
        logic [NW-1:0] name_f;
        logic          rdy;
        logic          emp;
    } vec_t;

    function automatic vec_t mkv(input bit ee, input int en, input bit we, input int wn, input bit cr,
                                 input bit fe, input int nf, input bit rdy, input bit emp);
        vec_t v;
        v.enq_e = ee;  v.enq_name = NW'(en);
        v.wb_e  = we;  v.wb_name  = NW'(wn);
        v.cr    = cr;  v.fe = fe; v.name_f = NW'(nf);
        v.rdy   = rdy; v.emp = emp;
        return v;
    endfunction

    typedef struct {
        logic [NW-1:0] nm;
        bit            dn;
    } ent_t;

    ent_t q[$];

    function automatic bit in_q(input logic [NW-1:0] n);
        foreach (q[k]) if (q[k].nm == n) return 1'b1;
        return 1'b0;
    endfunction

    vec_t vecs[38];

    initial begin
        int exp_commit;
        int exp_stall;

        // Enqueue/writeback/commit inputs, then expected FE, NAME_F, ENQ_READY, EMPTY
        // during that same cycle.
        vecs[0]  = mkv(1,2,0,0,0,   0,0,1,1);   // basic
        vecs[1]  = mkv(0,0,1,2,1,   0,2,1,0);   // WB of head: no FE this cycle
        vecs[2]  = mkv(0,0,0,0,1,   1,2,1,0);
        vecs[3]  = mkv(0,0,0,0,1,   0,0,1,1);
        vecs[4]  = mkv(1,2,0,0,0,   0,0,1,1);   // ordering
        vecs[5]  = mkv(1,3,0,0,0,   0,2,1,0);
        vecs[6]  = mkv(0,0,1,3,1,   0,2,1,0);
        vecs[7]  = mkv(0,0,1,2,1,   0,2,1,0);
        vecs[8]  = mkv(0,0,0,0,1,   1,2,1,0);
        vecs[9]  = mkv(0,0,0,0,1,   1,3,1,0);
        vecs[10] = mkv(0,0,0,0,1,   0,0,1,1);
        vecs[11] = mkv(1,1,0,0,0,   0,0,1,1);   // fill across the wrap
        vecs[12] = mkv(1,4,0,0,0,   0,1,1,0);
        vecs[13] = mkv(1,6,0,0,0,   0,1,1,0);
        vecs[14] = mkv(1,7,0,0,0,   0,1,1,0);
        vecs[15] = mkv(1,9,0,0,0,   0,1,0,0);   // full: ignored
        vecs[16] = mkv(0,0,1,1,1,   0,1,0,0);
        vecs[17] = mkv(1,9,1,4,1,   1,1,0,0);   // full and retiring: still ignored
        vecs[18] = mkv(0,0,1,6,1,   1,4,1,0);
        vecs[19] = mkv(0,0,1,7,1,   1,6,1,0);
        vecs[20] = mkv(0,0,0,0,1,   1,7,1,0);
        vecs[21] = mkv(0,0,0,0,1,   0,0,1,1);
        vecs[22] = mkv(1,5,1,5,1,   0,0,1,1);   // same-cycle enq+WB
        vecs[23] = mkv(0,0,0,0,1,   1,5,1,0);
        vecs[24] = mkv(0,0,0,0,1,   0,0,1,1);
        vecs[25] = mkv(1,8,0,0,0,   0,0,1,1);   // enq+commit at count=2
        vecs[26] = mkv(1,10,1,8,0,  0,8,1,0);
        vecs[27] = mkv(1,11,0,0,1,  1,8,1,0);
        vecs[28] = mkv(0,0,0,0,0,   0,10,1,0);
        vecs[29] = mkv(1,12,0,0,0,  0,10,1,0);
        vecs[30] = mkv(1,13,0,0,0,  0,10,1,0);
        vecs[31] = mkv(0,0,0,0,0,   0,10,0,0);  // count was 2, now full
        vecs[32] = mkv(0,0,1,10,0,  0,10,0,0);
        vecs[33] = mkv(0,0,1,11,1,  1,10,0,0);
        vecs[34] = mkv(0,0,1,12,1,  1,11,1,0);
        vecs[35] = mkv(0,0,1,13,1,  1,12,1,0);
        vecs[36] = mkv(0,0,0,0,1,   1,13,1,0);
        vecs[37] = mkv(0,0,0,0,1,   0,0,1,1);

        // Reset state
        RST = 1'b0;
        drive(0, 0, 0, 0, 1);
        #3;
        chk("reset ENQ_READY", ENQ_READY, 1);
        chk("reset FE",        FE,        0);
        chk("reset NAME_F",    NAME_F,    0);
        chk("reset EMPTY",     EMPTY,     1);
        @(negedge CLK);
        RST = 1'b1;
        step();

        // Directed table
        for (int i = 0; i < 38; i++) begin
            drive(vecs[i].enq_e, int'(vecs[i].enq_name), vecs[i].wb_e, int'(vecs[i].wb_name), vecs[i].cr);
            @(negedge CLK);
            $display("[TB] vec %0d enq=%0b/%0d wb=%0b/%0d cr=%0b -> fe=%0b name_f=%0d rdy=%0b empty=%0b",
                     i, ENQ_E, ENQ_NAME, WB_E, WB_NAME, COMMIT_READY, FE, NAME_F, ENQ_READY, EMPTY);
            chk($sformatf("vec%0d FE", i),        FE,        vecs[i].fe);
            chk($sformatf("vec%0d NAME_F", i),    NAME_F,    vecs[i].name_f);
            chk($sformatf("vec%0d ENQ_READY", i), ENQ_READY, vecs[i].rdy);
            chk($sformatf("vec%0d EMPTY", i),     EMPTY,     vecs[i].emp);
            step();
        end

        // Reset mid-run with three entries and a retirable head
        drive(1, 1, 0, 0, 0); step();
        drive(1, 2, 1, 1, 0); step();
        drive(1, 3, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1);
        #2;
        chk("prereset FE", FE, 1);
        RST = 1'b0;
        #1;
        $display("[TB] reset asserted mid-run -> fe=%0b rdy=%0b empty=%0b", FE, ENQ_READY, EMPTY);
        chk("midreset EMPTY",     EMPTY,     1);
        chk("midreset FE",        FE,        0);
        chk("midreset ENQ_READY", ENQ_READY, 1);
        chk("midreset NAME_F",    NAME_F,    0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            drive(0, 0, 1, i + 1, 1);
            @(negedge CLK);
            $display("[TB] post-reset cycle %0d -> fe=%0b empty=%0b", i, FE, EMPTY);
            chk($sformatf("postreset%0d FE", i),    FE,    0);
            chk($sformatf("postreset%0d EMPTY", i), EMPTY, 1);
        end
`ifdef RCQ_COMMIT_STATS_EN
        chk("postreset COMMIT_COUNT", COMMIT_COUNT, 0);
        chk("postreset STALL_COUNT",  STALL_COUNT,  0);
`endif
        step();

        // Backpressure: done head held by COMMIT_READY=0 for three cycles
        drive(1, 5, 1, 5, 0); step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            $display("[TB] backpressure cycle %0d -> fe=%0b name_f=%0d", i, FE, NAME_F);
            chk($sformatf("bp%0d FE", i),     FE,     0);
            chk($sformatf("bp%0d NAME_F", i), NAME_F, 5);
            step();
        end
        drive(0, 0, 0, 0, 1);
        @(negedge CLK);
        $display("[TB] backpressure release -> fe=%0b name_f=%0d", FE, NAME_F);
        chk("bp release FE",     FE,     1);
        chk("bp release NAME_F", NAME_F, 5);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("bp after EMPTY", EMPTY, 1);
`ifdef RCQ_COMMIT_STATS_EN
        chk("bp STALL_COUNT",  STALL_COUNT,  3);
        chk("bp COMMIT_COUNT", COMMIT_COUNT, 1);
`endif
        step();

        // Randomized traffic against the queue model (queue is empty here)
        q.delete();
        exp_commit = 1;
        exp_stall  = 3;
        for (int c = 0; c < 400; c++) begin
            logic          r_ee, r_we, r_cr;
            logic [NW-1:0] r_en, r_wn;
            bit            e_fe, e_rdy, e_stall;
            logic [NW-1:0] e_nf;

            r_ee = ($urandom_range(0, 1) == 1);
            r_en = '0;
            if (r_ee) begin
                r_ee = 1'b0;
                for (int t = 0; t < 64 && !r_ee; t++) begin
                    r_en = NW'($urandom_range(0, (1 << NW) - 1));
                    if (!in_q(r_en)) r_ee = 1'b1;
                end
            end
            r_we = ($urandom_range(0, 1) == 1);
            if (q.size() > 0 && $urandom_range(0, 9) < 7)
                r_wn = q[$urandom_range(0, q.size() - 1)].nm;
            else if ($urandom_range(0, 3) == 0)
                r_wn = r_en;
            else
                r_wn = NW'($urandom_range(0, (1 << NW) - 1));
            r_cr = ($urandom_range(0, 3) != 0);

            drive(r_ee, int'(r_en), r_we, int'(r_wn), r_cr);

            e_rdy   = (q.size() < D);
            e_fe    = (q.size() > 0) && q[0].dn && r_cr;
            e_nf    = (q.size() > 0) ? q[0].nm : '0;
            e_stall = (q.size() > 0) && (!q[0].dn || !r_cr);

            @(negedge CLK);
            $display("[TB] rnd %0d enq=%0b/%0d wb=%0b/%0d cr=%0b -> fe=%0b name_f=%0d rdy=%0b empty=%0b",
                     c, r_ee, r_en, r_we, r_wn, r_cr, FE, NAME_F, ENQ_READY, EMPTY);
            chk($sformatf("rnd%0d FE", c),        FE,        e_fe);
            chk($sformatf("rnd%0d NAME_F", c),    NAME_F,    e_nf);
            chk($sformatf("rnd%0d ENQ_READY", c), ENQ_READY, e_rdy);
            chk($sformatf("rnd%0d EMPTY", c),     EMPTY,     q.size() == 0);
`ifdef RCQ_COMMIT_STATS_EN
            chk($sformatf("rnd%0d COMMIT_COUNT", c), COMMIT_COUNT, exp_commit);
            chk($sformatf("rnd%0d STALL_COUNT", c),  STALL_COUNT,  exp_stall);
`endif
            // Model update for the coming edge
            if (r_we) begin
                foreach (q[k]) if (q[k].nm == r_wn) q[k].dn = 1'b1;
            end
            if (e_fe) begin
                void'(q.pop_front());
                exp_commit++;
            end
            if (e_stall) exp_stall++;
            if (r_ee && e_rdy) q.push_back('{nm: r_en, dn: (r_we && (r_wn == r_en))});
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
